// File: rtl/usb_in_ep_arbiter_pkg.sv
// Shared definitions for the USB IN endpoint arbiter: FSM state encoding,
// endpoint index constants and a small index helper.
package usb_in_ep_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANTED  = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_t;

  // Endpoint client indices; EP0 (control) is the first one served after reset
  localparam int EP_CTRL    = 0;
  localparam int EP_BULK_TX = 1;
  localparam int EP_NOTIFY  = 2;

  localparam int LANE_W = 8;

  // Next index after idx, wrapping from n-1 back to 0
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/usb_in_ep_arbiter_rr_arbiter.sv
// Round-robin picker: finds the first requester at or after ptr, wrapping
// around. Rotates the request vector so ptr lands at bit 0, priority-encodes
// the lowest set bit, then rotates the offset back into an absolute index.
module usb_in_ep_arbiter_rr_arbiter
  import usb_in_ep_arbiter_pkg::*;
#(
  parameter int NUM_EP = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_EP-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  pick,
  output logic              valid
);

  localparam int DBL_W = $clog2(2 * NUM_EP);

  logic [2*NUM_EP-1:0] req_dbl;
  logic [NUM_EP-1:0]   req_rot;
  logic [DBL_W-1:0]    ptr_ext;
  logic [IDX_W-1:0]    offset;
  logic [IDX_W:0]      sum;

  assign req_dbl = {req, req};
  assign ptr_ext = DBL_W'(ptr);
  assign req_rot = req_dbl[ptr_ext +: NUM_EP];

  // Lowest set bit of the rotated vector is the nearest requester to ptr
  always_comb begin
    offset = '0;
    valid  = 1'b0;
    for (int k = NUM_EP - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = IDX_W'(k);
        valid  = 1'b1;
      end
    end
  end

  // Rotate the offset back to an absolute endpoint index, modulo NUM_EP
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(NUM_EP)) begin
      sum = sum - (IDX_W + 1)'(NUM_EP);
    end
    pick = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/usb_in_ep_arbiter.sv
// Shares the single USB IN packet buffer between NUM_EP endpoint clients.
// Ownership is granted round-robin and held for a whole packet: fill,
// done/stall, then the host ACK (or a timeout / client abort flushes it).
module usb_in_ep_arbiter
  import usb_in_ep_arbiter_pkg::*;
#(
  parameter int          NUM_EP      = 3,
  parameter logic [15:0] ACK_TIMEOUT = 16'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EP-1:0]     ep_req,
  output logic [NUM_EP-1:0]     ep_grant,
  input  logic [NUM_EP-1:0]     ep_data_put,
  input  logic [8*NUM_EP-1:0]   ep_data,
  input  logic [NUM_EP-1:0]     ep_data_done,
  input  logic [NUM_EP-1:0]     ep_stall,
  output logic [NUM_EP-1:0]     ep_data_free,
  output logic [NUM_EP-1:0]     ep_acked,
  input  logic                  buf_data_free,
  output logic                  buf_data_put,
  output logic [7:0]            buf_data,
  output logic                  buf_data_done,
  output logic                  buf_stall,
  input  logic                  buf_acked,
  output logic                  buf_flush,
  output logic [1:0]            buf_owner
);

  localparam int IDX_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  arb_state_t          state;
  logic [NUM_EP-1:0]   grant;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [15:0]         ack_cnt;

  logic [IDX_W-1:0]    pick;
  logic                pick_valid;
  logic [NUM_EP-1:0]   pick_onehot;
  logic [IDX_W-1:0]    rr_next;
  logic [LANE_W-1:0]   lane [NUM_EP];

  logic                in_granted;
  logic                in_wait;
  logic                owner_end;
  logic                owner_abort;
  logic                ack_hit;
  logic                timeout_hit;

  usb_in_ep_arbiter_rr_arbiter #(
    .NUM_EP (NUM_EP),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (ep_req),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  for (genvar i = 0; i < NUM_EP; i++) begin : g_lane
    assign lane[i] = ep_data[LANE_W*i +: LANE_W];
  end

  assign pick_onehot = {{(NUM_EP-1){1'b0}}, 1'b1} << pick;
  assign rr_next     = IDX_W'(next_index(int'(owner), NUM_EP));

  assign in_granted  = (state == ST_GRANTED);
  assign in_wait     = (state == ST_WAIT_ACK);
  assign owner_end   = in_granted & (ep_data_done[owner] | ep_stall[owner]);
  assign owner_abort = in_granted & ~ep_req[owner] & ~owner_end;
  assign ack_hit     = in_wait & buf_acked;
  // An ACK arriving on the last timeout cycle still wins over the flush
  assign timeout_hit = in_wait & ~buf_acked & (ACK_TIMEOUT != 16'd0) &
                       (ack_cnt == ACK_TIMEOUT - 16'd1);

  // Only the owner's lane reaches the buffer, and only while filling
  assign buf_data_put  = in_granted & ep_data_put[owner];
  assign buf_data      = in_granted ? lane[owner] : 8'h00;
  assign buf_data_done = in_granted & ep_data_done[owner];
  assign buf_stall     = in_granted & ep_stall[owner];
  assign buf_flush     = owner_abort | timeout_hit;

  assign ep_grant     = grant;
  assign ep_acked     = ack_hit ? grant : '0;
  assign ep_data_free = grant & {NUM_EP{buf_data_free & in_granted}};
  assign buf_owner    = 2'(owner);

  // Packet ownership FSM: grant/owner/pointer registers and ACK timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= IDX_W'(EP_CTRL);
      ack_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_onehot;
            owner <= pick;
            state <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (owner_end) begin
            ack_cnt <= '0;
            state   <= ST_WAIT_ACK;
          end else if (owner_abort) begin
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= rr_next;
            state  <= ST_IDLE;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_hit || timeout_hit) begin
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= rr_next;
            state  <= ST_IDLE;
          end else if (ack_cnt != 16'hFFFF) begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
